// File: rtl/iso14443a_tagsim_sequencer.sv
// Drives mod_type for the hi_iso14443a tag-simulation datapath. While the reader
// transmits it holds TAGSIM_LISTEN. After the reader's end-of-frame it waits out the
// frame delay time, modulates for the armed response length, then holds listen for a
// guard time. Every other mode is passed through from req_mode with one cycle of latency.
module iso14443a_tagsim_sequencer #(
  parameter int unsigned FDT_0     = 1172,  // frame delay when the last reader bit was 0
  parameter int unsigned FDT_1     = 1236,  // frame delay when the last reader bit was 1
  parameter int unsigned PIPE_COMP = 0,     // modulation-path latency, must be < FDT_0
  parameter int unsigned BIT_CYC   = 128,   // carrier cycles per response bit
  parameter int unsigned GUARD_CYC = 1024,  // listen-only cycles after a response, >= 1
  parameter int unsigned LEN_W     = 9
) (
  input  logic             ck_1356meg,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [2:0]       req_mode,
  input  logic             rx_eof,
  input  logic             last_bit,
  input  logic             tx_arm,
  input  logic [LEN_W-1:0] tx_len,
  output logic             tx_ready,
  output logic [2:0]       mod_type,
  output logic             tx_bit_req,
  output logic             tx_done,
  output logic             tx_abort,
  output logic             busy
);

  localparam int unsigned FdtMax = (FDT_0 > FDT_1) ? FDT_0 : FDT_1;
  localparam int unsigned DlyMax = (FdtMax > GUARD_CYC) ? FdtMax : GUARD_CYC;
  localparam int unsigned DlyW   = $clog2(DlyMax + 1);
  localparam int unsigned BitW   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  // The delay counter is shared by WAIT_FDT and GUARD; both load N-1 and exit at 0.
  localparam logic [DlyW-1:0] Fdt0Load  = DlyW'(FDT_0 - PIPE_COMP - 1);
  localparam logic [DlyW-1:0] Fdt1Load  = DlyW'(FDT_1 - PIPE_COMP - 1);
  localparam logic [DlyW-1:0] GuardLoad = DlyW'(GUARD_CYC - 1);
  localparam logic [BitW-1:0] BitLast   = BitW'(BIT_CYC - 1);

  localparam logic [2:0] ModTagListen = 3'b001;
  localparam logic [2:0] ModTagMod    = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StListen,
    StArmed,
    StWaitFdt,
    StModulate,
    StGuard
  } state_e;

  state_e           state_q, state_d;
  logic [DlyW-1:0]  dly_q, dly_d;
  logic [BitW-1:0]  bitc_q, bitc_d;   // cycle within the current response bit
  logic [LEN_W-1:0] bidx_q, bidx_d;   // response bits already completed
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bidx_inc;
  logic [2:0]       mod_d;
  logic             ready_d, bit_req_d, done_d, abort_d, busy_d;
  logic             active;
  logic [DlyW-1:0]  fdt_load;

  assign active   = enable && (req_mode == ModTagListen);
  assign fdt_load = last_bit ? Fdt1Load : Fdt0Load;
  // bidx_q never exceeds len_q - 1, so the increment cannot wrap even at the maximum length.
  assign bidx_inc = bidx_q + LEN_W'(1);

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    bitc_d    = bitc_q;
    bidx_d    = bidx_q;
    len_d     = len_q;
    mod_d     = ModTagListen;
    bit_req_d = 1'b0;
    done_d    = 1'b0;
    abort_d   = 1'b0;

    if (!active) begin
      // Leaving tag-sim always wins; only a response already on air is reported.
      state_d = StIdle;
      mod_d   = req_mode;
      abort_d = (state_q == StModulate);
      dly_d   = '0;
      bitc_d  = '0;
      bidx_d  = '0;
      len_d   = '0;
    end else begin
      case (state_q)
        StIdle: state_d = StListen;
        StListen: begin
          // An eof arriving with the arm is dropped: that frame gets no response.
          if (tx_arm && (tx_len != '0)) begin
            len_d   = tx_len;
            state_d = StArmed;
          end
        end
        StArmed: begin
          if (rx_eof) begin
            dly_d   = fdt_load;
            state_d = StWaitFdt;
          end
        end
        StWaitFdt: begin
          if (rx_eof) begin
            // Reader restarted its frame; time the delay from the newest eof.
            dly_d = fdt_load;
          end else if (dly_q == '0) begin
            state_d   = StModulate;
            mod_d     = ModTagMod;
            bitc_d    = '0;
            bidx_d    = '0;
            bit_req_d = 1'b1;
          end else begin
            dly_d = dly_q - DlyW'(1);
          end
        end
        StModulate: begin
          mod_d = ModTagMod;
          if (bitc_q == BitLast) begin
            bitc_d = '0;
            if (bidx_inc == len_q) begin
              state_d = StGuard;
              mod_d   = ModTagListen;
              done_d  = 1'b1;
              dly_d   = GuardLoad;
              bidx_d  = '0;
              len_d   = '0;
            end else begin
              bidx_d    = bidx_inc;
              bit_req_d = 1'b1;
            end
          end else begin
            bitc_d = bitc_q + BitW'(1);
          end
        end
        StGuard: begin
          if (dly_q == '0) begin
            state_d = StListen;
          end else begin
            dly_d = dly_q - DlyW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    ready_d = (state_d == StListen);
    busy_d  = (state_d == StArmed) || (state_d == StWaitFdt) ||
              (state_d == StModulate) || (state_d == StGuard);
  end

  // State, counters and all outputs are registered.
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dly_q      <= '0;
      bitc_q     <= '0;
      bidx_q     <= '0;
      len_q      <= '0;
      mod_type   <= 3'b000;
      tx_ready   <= 1'b0;
      tx_bit_req <= 1'b0;
      tx_done    <= 1'b0;
      tx_abort   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      bitc_q     <= bitc_d;
      bidx_q     <= bidx_d;
      len_q      <= len_d;
      mod_type   <= mod_d;
      tx_ready   <= ready_d;
      tx_bit_req <= bit_req_d;
      tx_done    <= done_d;
      tx_abort   <= abort_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_iso14443a_tagsim_sequencer.sv
// Scoreboard bench: each scenario works out, from the frame-timing rules, the edge at
// which every output event must happen and queues it; a monitor turns output changes
// and pulses into events and checks them against the queue.
module tb_iso14443a_tagsim_sequencer;

  localparam int unsigned FDT_0 = 1172;
  localparam int unsigned FDT_1 = 1236;
  localparam int unsigned PIPE  = 20;
  localparam int unsigned BIT   = 128;
  localparam int unsigned GUARD = 1024;
  localparam int unsigned LEN_W = 8;
  localparam longint      Never = 64'sd1 << 40;

  // Event kinds, in the order the monitor reports events within one cycle.
  localparam int EvMod = 0, EvBit = 1, EvDone = 2, EvAbort = 3, EvRdy = 4, EvBusy = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [2:0]       req_mode = 3'd0;
  logic             rx_eof = 1'b0;
  logic             last_bit = 1'b0;
  logic             tx_arm = 1'b0;
  logic [LEN_W-1:0] tx_len = '0;
  logic             tx_ready, tx_bit_req, tx_done, tx_abort, busy;
  logic [2:0]       mod_type;

  iso14443a_tagsim_sequencer #(
    .FDT_0(FDT_0), .FDT_1(FDT_1), .PIPE_COMP(PIPE), .BIT_CYC(BIT),
    .GUARD_CYC(GUARD), .LEN_W(LEN_W)
  ) dut (
    .ck_1356meg(clk), .rst_n(rst_n), .enable(enable), .req_mode(req_mode),
    .rx_eof(rx_eof), .last_bit(last_bit), .tx_arm(tx_arm), .tx_len(tx_len),
    .tx_ready(tx_ready), .mod_type(mod_type), .tx_bit_req(tx_bit_req),
    .tx_done(tx_done), .tx_abort(tx_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  longint cyc = 0;  // number of the most recent rising edge
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     kind;
    int     val;
    longint t;
  } ev_t;

  ev_t        exp_q[$];
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 1'b0;
  logic [2:0] p_mod;
  logic       p_rdy, p_busy;

  function automatic void push(int kind, int val, longint t);
    ev_t e;
    int  i;
    e.kind = kind;
    e.val  = val;
    e.t    = t;
    i = 0;
    while (i < exp_q.size() &&
           (exp_q[i].t < t || (exp_q[i].t == t && exp_q[i].kind <= kind))) i++;
    exp_q.insert(i, e);
  endfunction

  task automatic see(int kind, int val);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL event: got kind=%0d val=%0d at edge %0d, required none", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.t != cyc) begin
        bad++;
        $display("FAIL event: got kind=%0d val=%0d edge=%0d, required kind=%0d val=%0d edge=%0d",
                 kind, val, cyc, e.kind, e.val, e.t);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mod_type !== p_mod) see(EvMod, int'(mod_type));
        if (tx_bit_req)         see(EvBit, 1);
        if (tx_done)            see(EvDone, 1);
        if (tx_abort)           see(EvAbort, 1);
        if (tx_ready !== p_rdy) see(EvRdy, int'(tx_ready));
        if (busy !== p_busy)    see(EvBusy, int'(busy));
      end
      p_mod  = mod_type;
      p_rdy  = tx_ready;
      p_busy = busy;
    end
  endtask

  task automatic check(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic check_drained(string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d events never seen (first kind=%0d edge=%0d), required 0",
               name, exp_q.size(), exp_q[0].kind, exp_q[0].t);
      exp_q.delete();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint fdt(bit b);
    return longint'(b ? FDT_1 : FDT_0) - longint'(PIPE);
  endfunction

  function automatic logic [2:0] other_mode();
    case ($urandom_range(0, 3))
      0:       return 3'd0;
      1:       return 3'd2;
      2:       return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  // One response attempt starting from LISTEN. dk picks where tag-sim is left:
  // 0 never, 1 ARMED, 2 WAIT_FDT, 3 MODULATE (bit j, roff cycles in), 4 GUARD.
  task automatic scenario(int L, bit b0, bit re, int d, bit b1, int dk, int j, int roff,
                          bit via_req, logic [2:0] dmode, int gap, bit pre0, bit arm_eof);
    longint     a, e0, e1, s, dd, r, x, y, tend;
    int         g, prev_mod;
    bit         inmod;
    logic [2:0] dm;
    dm = via_req ? dmode : 3'd1;
    if (pre0) begin  // a zero-length arm must be ignored
      tx_arm = 1'b1;
      tx_len = '0;
      step();
    end
    a  = cyc + 1;
    g  = $urandom_range(1, 6);
    e0 = a + g;
    e1 = e0 + d;
    s  = re ? e1 + fdt(b1) : e0 + fdt(b0);
    dd = s + longint'(L) * BIT;
    r  = dd + GUARD;
    case (dk)
      1:       x = a + 1 + (roff % g);
      2:       x = e0 + 1 + roff;
      3:       x = s + longint'(j) * BIT + roff;
      4:       x = dd + roff;
      default: x = Never;
    endcase
    y = (dk != 0) ? x + gap : Never;

    push(EvRdy, 0, a);
    push(EvBusy, 1, a);
    if (x > e0) begin
      if (s < x) push(EvMod, 2, s);
      for (int k = 0; k < L; k++) if (s + longint'(k) * BIT < x) push(EvBit, 1, s + k * BIT);
      if (dd < x) begin
        push(EvMod, 1, dd);
        push(EvDone, 1, dd);
      end
      if (r < x) begin
        push(EvRdy, 1, r);
        push(EvBusy, 0, r);
      end
    end
    if (dk != 0) begin
      inmod    = (x > e0) && (s < x) && (x <= dd);
      prev_mod = inmod ? 2 : 1;
      if (int'(dm) != prev_mod) push(EvMod, int'(dm), x);
      if (inmod) push(EvAbort, 1, x);
      push(EvBusy, 0, x);
      if (dm != 3'd1) push(EvMod, 1, y);
      push(EvRdy, 1, y);
    end
    tend = (dk != 0) ? y + 3 : r + 3;

    for (longint e = a; e <= tend; e++) begin
      tx_arm = (e == a);
      tx_len = (e == a) ? LEN_W'(L) : LEN_W'($urandom);
      if (e > a && e < x && e <= r && $urandom_range(0, 7) == 0) tx_arm = 1'b1;
      rx_eof = (e == e0) || (re && e == e1) || (e == a && arm_eof) ||
               (e > s && $urandom_range(0, 15) == 0);
      if (re && e == e1)  last_bit = b1;
      else if (e == e0)   last_bit = b0;
      else                last_bit = 1'($urandom);
      if (e >= x && e < y) begin
        enable   = via_req;
        req_mode = dm;
      end else begin
        enable   = 1'b1;
        req_mode = 3'd1;
      end
      step();
    end
    tx_arm = 1'b0;
    rx_eof = 1'b0;
    check_drained("scenario drained");
  endtask

  initial begin
    int L, dk, j, roff;
    fork
      monitor();
    join_none

    // Reset values, with the tag-sim path already requested.
    enable   = 1'b1;
    req_mode = 3'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset outputs", int'({mod_type, tx_ready, tx_bit_req, tx_done, tx_abort, busy}), 0);
    end
    rst_n = 1'b1;
    step();
    step();
    check("listen mod_type", int'(mod_type), 1);
    check("listen tx_ready", int'(tx_ready), 1);
    check("listen busy", int'(busy), 0);
    mon_en = 1'b1;

    // Directed responses: both FDT values, a restarted frame, an abort at bit 2.
    scenario(4, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 1'b0, 3'd1, 0, 1'b0, 1'b0);
    scenario(4, 1'b1, 1'b0, 0, 1'b0, 0, 0, 0, 1'b0, 3'd1, 0, 1'b1, 1'b1);
    scenario(3, 1'($urandom), 1'b1, 300, 1'($urandom), 0, 0, 0, 1'b0, 3'd1, 0, 1'b0, 1'b0);
    scenario(8, 1'b0, 1'b0, 0, 1'b0, 3, 2, 50, 1'b0, 3'd1, 20, 1'b0, 1'b0);

    // Randomized responses and deactivation points.
    for (int n = 0; n < 4; n++) begin
      L  = $urandom_range(1, 8);
      dk = $urandom_range(0, 4);
      j  = $urandom_range(0, L - 1);
      case (dk)
        2:       roff = $urandom_range(0, 999);
        3:       roff = $urandom_range(1, BIT);
        4:       roff = $urandom_range(1, GUARD);
        default: roff = $urandom_range(0, 7);
      endcase
      scenario(L, 1'($urandom), 1'($urandom), $urandom_range(1, 1100), 1'($urandom), dk, j,
               roff, 1'($urandom), other_mode(), $urandom_range(1, 30), 1'($urandom),
               1'($urandom));
    end

    // Longest response the length field allows, left during the guard time.
    scenario((1 << LEN_W) - 1, 1'($urandom), 1'b0, 0, 1'b0, 4, 0, 5, 1'b0, 3'd1, 3, 1'b0,
             1'b0);

    // Reader-listen mode passes through; tag-sim controls do nothing.
    mon_en   = 1'b0;
    req_mode = 3'd3;
    step();
    check("mode011 mod_type", int'(mod_type), 3);
    check("mode011 tx_ready", int'(tx_ready), 0);
    check("mode011 busy", int'(busy), 0);
    for (int i = 0; i < 20; i++) begin
      tx_arm   = 1'($urandom);
      tx_len   = LEN_W'($urandom);
      rx_eof   = 1'($urandom);
      last_bit = 1'($urandom);
      step();
      check("mode011 quiet", int'({mod_type, tx_ready, tx_bit_req, tx_done, tx_abort, busy}),
            int'({3'd3, 5'b0}));
    end
    tx_arm   = 1'b0;
    rx_eof   = 1'b0;
    req_mode = 3'd1;
    step();
    check("relisten mod_type", int'(mod_type), 1);
    check("relisten tx_ready", int'(tx_ready), 1);
    step();
    mon_en = 1'b1;
    rx_eof = 1'b1;  // no response may be pending
    step();
    rx_eof = 1'b0;
    for (int i = 0; i < 1400; i++) step();
    check_drained("no residual response");

    // Asynchronous reset in the middle of a response.
    mon_en = 1'b0;
    tx_arm = 1'b1;
    tx_len = LEN_W'(3);
    step();
    tx_arm   = 1'b0;
    rx_eof   = 1'b1;
    last_bit = 1'b0;
    step();
    rx_eof = 1'b0;
    for (int i = 0; i < 2000 && mod_type != 3'd2; i++) step();
    check("async pre mod_type", int'(mod_type), 2);
    for (int i = 0; i < 40; i++) step();
    #3 rst_n = 1'b0;
    #1;
    check("async reset outputs", int'({mod_type, tx_ready, tx_bit_req, tx_done, tx_abort, busy}),
          0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("held reset outputs", int'({mod_type, tx_ready, tx_bit_req, tx_done, tx_abort, busy}),
            0);
    end
    rst_n = 1'b1;
    step();
    step();
    check("post reset mod_type", int'(mod_type), 1);
    check("post reset tx_ready", int'(tx_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iso14443a_tagsim_sequencer.md
Name: iso14443a_tagsim_sequencer

Overview:
- Sequences the hi_iso14443a tag-simulation datapath by driving its mod_type input.
- Holds TAGSIM_LISTEN while the reader transmits. After the reader's end-of-frame it waits the ISO14443A frame delay time, switches to TAGSIM_MOD for exactly the armed response length, then returns to listen after a guard time.
- Sits between the ARM-side SSP/config logic and hi_iso14443a; all other modes pass through it unchanged.

Parameters:
- FDT_0, 1172, frame delay in carrier cycles when the last reader bit was 0.
- FDT_1, 1236, frame delay in carrier cycles when the last reader bit was 1.
- PIPE_COMP, 0, carrier cycles subtracted from FDT to compensate modulation-path latency; must be less than FDT_0.
- BIT_CYC, 128, carrier cycles per response bit.
- GUARD_CYC, 1024, listen-only cycles after a response.
- LEN_W, 9, width of tx_len.

Ports:
- ck_1356meg  in  1  13.56 MHz carrier clock; only clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  sequencer enable.
- req_mode  in  3  ARM-requested mode: 000 SNIFFER, 001 TAGSIM_LISTEN, 010 TAGSIM_MOD, 011 READER_LISTEN, 100 READER_MOD.
- rx_eof  in  1  one-cycle pulse: reader frame ended (last pause detected).
- last_bit  in  1  value of the last reader bit; valid while rx_eof is high.
- tx_arm  in  1  response-load strobe; accepted only while tx_ready is high.
- tx_len  in  LEN_W  response length in bits; captured on an accepted tx_arm.
- tx_ready  out  1  high when a response can be armed.
- mod_type  out  3  mode fed to hi_iso14443a.
- tx_bit_req  out  1  one-cycle pulse at the start of each response bit period.
- tx_done  out  1  one-cycle pulse when a response completes normally.
- tx_abort  out  1  one-cycle pulse when a response is killed mid-flight.
- busy  out  1  high in the ARMED, WAIT_FDT, MODULATE and GUARD states.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, mod_type 000, tx_ready 0, tx_bit_req 0, tx_done 0, tx_abort 0, busy 0, all counters 0.
- The tag-sim path is active when enable=1 and req_mode=001.
- When the tag-sim path is inactive:
  - The state is forced to IDLE on the next edge.
  - mod_type = req_mode, registered with 1-cycle latency.
- State machine:
  - IDLE: enters LISTEN when the tag-sim path becomes active.
  - LISTEN: mod_type=001, tx_ready=1.
    - tx_arm with tx_len≠0 → ARMED; tx_len is latched and tx_ready drops on the next edge.
    - tx_arm with tx_len=0 is ignored.
    - rx_eof is ignored.
  - ARMED: mod_type=001. rx_eof → WAIT_FDT; the delay counter is loaded with N−1, where N = (last_bit ? FDT_1 : FDT_0) − PIPE_COMP.
  - WAIT_FDT: mod_type=001; the counter decrements each cycle.
    - At 0 → MODULATE.
    - Timing: if rx_eof is sampled at edge E0, mod_type reads 010 from edge E0+N.
    - A new rx_eof during WAIT_FDT reloads the counter using the new last_bit; the reader restarted its frame.
  - MODULATE: mod_type=010 for exactly tx_len×BIT_CYC cycles.
    - tx_bit_req pulses in the first cycle of MODULATE and every BIT_CYC cycles after that, giving exactly tx_len pulses.
    - The bit counter counts up to tx_len; a maximum tx_len of 2^LEN_W−1 must not overflow it.
    - rx_eof is ignored.
    - After the last cycle: mod_type=001, tx_done pulses on the same edge, state → GUARD.
  - GUARD: mod_type=001 for GUARD_CYC cycles. rx_eof is ignored and tx_ready=0. Then → LISTEN.
- Simultaneous events:
  - tx_arm and rx_eof in the same LISTEN cycle: the arm is accepted, the eof is not used (no response for that frame).
  - Deactivation takes priority over every other event.
- Deactivation (enable=0 or req_mode≠001):
  - From ARMED or WAIT_FDT → IDLE, latched response discarded, no tx_done, no tx_abort.
  - From MODULATE → IDLE, tx_abort pulses once, mod_type=req_mode on the next edge, no tx_done.
  - From GUARD → IDLE silently.
- Asynchronous reset mid-operation: everything clears immediately to reset values, with no pulses generated.
- busy equals state ∈ {ARMED, WAIT_FDT, MODULATE, GUARD}.

Test Plan:
- Reset, then enable=1, req_mode=001 → mod_type 000 during reset, 001 within 2 cycles; tx_ready=1.
- Arm tx_len=4, then rx_eof with last_bit=0 at edge E0 → mod_type=010 from E0+1172 to E0+1172+511; 4 tx_bit_req pulses at offsets 0, 128, 256, 384; tx_done once; tx_ready back to 1 after 1024 further cycles.
- Same sequence with last_bit=1 and PIPE_COMP=20 → mod_type=010 from E0+1216.
- Second rx_eof 300 cycles into WAIT_FDT → modulation starts FDT after the second eof; exactly one response.
- enable dropped at bit 2 of an 8-bit response → tx_abort single pulse; mod_type=req_mode on the next edge; no tx_done; later re-enable returns to LISTEN with no residual response.
- req_mode=011 with enable=1 → mod_type=011 after 1 cycle; rx_eof and tx_arm have no effect; tx_ready=0; busy=0.
